// File: rtl/si_pkg.sv
// Shared definitions for the Space Invaders VGA pipeline.
//
// Contents:
//   SCREEN_WIDTH / SCREEN_HEIGHT : visible raster size in pixels / lines
//   color_t                      : layer code handed to the compositor
//   laser_state_t                : player laser shot state encoding
package si_pkg;

   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;

   // Layer codes; NONE tells the compositor this layer is transparent here
   typedef enum logic [2:0] {
      BACKGROUND = 3'd0,
      SPACESHIP  = 3'd1,
      ALIENS0    = 3'd2,
      ALIENS1    = 3'd3,
      ALIENS2    = 3'd4,
      ALIENS3    = 3'd5,
      LASER      = 3'd6,
      NONE       = 3'd7
   } color_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } laser_state_t;

endpackage

// File: rtl/player_ship_ctrl_if.sv
// Player-ship bundle between the raster/input side and the ship block.
//
// Signals:
//   left, right, fire  : player controls (levels)
//   frameStart         : one-clock pulse at start of vertical blanking
//   hPos, vPos         : current pixel column / line
//   laserHit           : collision logic kills the laser (one-clock pulse)
//   gunPosition        : ship centre x
//   laserX, laserY     : laser centre x / top y
//   laserActive        : laser in flight
//   color              : per-pixel layer code for the compositor
// Modports:
//   master : drives controls and raster position, observes ship outputs
//   slave  : the ship block itself
interface player_ship_ctrl_if;
   import si_pkg::*;

   logic       left;
   logic       right;
   logic       fire;
   logic       frameStart;
   logic [9:0] hPos;
   logic [9:0] vPos;
   logic       laserHit;
   logic [9:0] gunPosition;
   logic [9:0] laserX;
   logic [9:0] laserY;
   logic       laserActive;
   color_t     color;

   modport master (
      output left, right, fire, frameStart, hPos, vPos, laserHit,
      input  gunPosition, laserX, laserY, laserActive, color
   );

   modport slave (
      input  left, right, fire, frameStart, hPos, vPos, laserHit,
      output gunPosition, laserX, laserY, laserActive, color
   );

endinterface

// File: rtl/player_ship_ctrl_laser_shot.sv
// Single player laser shot: launch, flight, kill and cooldown.
//
// Ports:
//   clk          : pixel clock
//   reset        : asynchronous active-low reset
//   fire_edge    : rising edge of the fire button (one clock)
//   frame_start  : one-clock pulse per frame
//   laser_hit    : collision kill pulse
//   gun_position : ship centre x, captured as the launch column
//   laser_x      : laser centre x
//   laser_y      : laser top y
//   laser_active : laser in flight
module laser_shot #(
   parameter int LAUNCH_Y        = 428,
   parameter int V_OFFSET        = 10,
   parameter int LASER_SPEED     = 8,
   parameter int COOLDOWN_FRAMES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fire_edge,
   input  logic       frame_start,
   input  logic       laser_hit,
   input  logic [9:0] gun_position,
   output logic [9:0] laser_x,
   output logic [9:0] laser_y,
   output logic       laser_active
);
   import si_pkg::*;

   localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
   localparam logic [9:0] LAUNCH_Y_V   = 10'(LAUNCH_Y);
   localparam logic [9:0] SPEED_V      = 10'(LASER_SPEED);
   // A shot this close to the top would leave the playfield on its next step
   localparam logic [9:0] EXIT_Y_V     = 10'(V_OFFSET + LASER_SPEED);
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_FRAMES - 1);

   laser_state_t    state;
   logic [CD_W-1:0] cooldown_cnt;

   // Shot FSM. Fire edges outside IDLE and hits outside FLYING fall through
   // the case arms untouched, so they are dropped rather than queued.
   // A hit wins over a same-cycle frameStart so a killed shot never moves.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cooldown_cnt <= '0;
         laser_x      <= '0;
         laser_y      <= '0;
         laser_active <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fire_edge) begin
                  state        <= FLYING;
                  laser_x      <= gun_position;
                  laser_y      <= LAUNCH_Y_V;
                  laser_active <= 1'b1;
               end
            end
            FLYING: begin
               if (laser_hit) begin
                  state        <= COOLDOWN;
                  cooldown_cnt <= '0;
                  laser_active <= 1'b0;
               end else if (frame_start) begin
                  if (laser_y < EXIT_Y_V) begin
                     state        <= COOLDOWN;
                     cooldown_cnt <= '0;
                     laser_active <= 1'b0;
                  end else begin
                     laser_y <= laser_y - SPEED_V;
                  end
               end
            end
            COOLDOWN: begin
               if (frame_start) begin
                  if (cooldown_cnt == CD_LAST) begin
                     state        <= IDLE;
                     cooldown_cnt <= '0;
                  end else begin
                     cooldown_cnt <= cooldown_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               laser_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/player_ship_ctrl.sv
// Player ship: gun movement, fire edge detection and per-pixel colour.
//
// Ports:
//   clk   : pixel clock
//   reset : asynchronous active-low reset
//   bus   : player_ship_ctrl_if.slave bundle (controls, raster position,
//           laser kill in; gun/laser state and colour code out)
module player_ship_ctrl #(
   parameter int SCREEN_WIDTH    = si_pkg::SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT   = si_pkg::SCREEN_HEIGHT,
   parameter int SHIP_WIDTH      = 60,
   parameter int SHIP_HEIGHT     = 30,
   parameter int H_OFFSET        = 10,
   parameter int V_OFFSET        = 10,
   parameter int STEP            = 20,
   parameter int MOVE_DIV        = 2,
   parameter int RECT_PERCENT    = 15,
   parameter int LASER_LEN       = 12,
   parameter int LASER_SPEED     = 8,
   parameter int COOLDOWN_FRAMES = 4
) (
   input logic                clk,
   input logic                reset,
   player_ship_ctrl_if.slave  bus
);
   import si_pkg::*;

   localparam int PMIN       = H_OFFSET + SHIP_WIDTH / 2;
   localparam int PMAX       = SCREEN_WIDTH - H_OFFSET - SHIP_WIDTH / 2;
   localparam int SHIP_TOP   = SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT;
   localparam int RECT_WIDTH = SHIP_WIDTH * RECT_PERCENT / 100;
   localparam int MV_W       = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

   // Position arithmetic runs in 11 bits so sums and margins never wrap
   localparam logic [10:0] PMIN_X      = 11'(PMIN);
   localparam logic [10:0] PMAX_X      = 11'(PMAX);
   localparam logic [10:0] STEP_X      = 11'(STEP);
   localparam logic [10:0] HALF_W_X    = 11'(SHIP_WIDTH / 2);
   localparam logic [10:0] HALF_RECT_X = 11'(RECT_WIDTH / 2);
   localparam logic [10:0] TOP_X       = 11'(SHIP_TOP);
   localparam logic [10:0] MID_X       = 11'(SHIP_TOP + SHIP_HEIGHT / 2);
   localparam logic [10:0] BOTTOM_X    = 11'(SHIP_TOP + SHIP_HEIGHT);
   localparam logic [10:0] LEN_X       = 11'(LASER_LEN);
   localparam logic [MV_W-1:0] MV_LAST = MV_W'(MOVE_DIV - 1);

   logic [MV_W-1:0] move_cnt;
   logic            move_ok;
   logic [9:0]      gun_q;
   logic [9:0]      next_gun;
   logic [10:0]     gun_ext;
   logic [10:0]     right_sum;
   logic            fire_d;
   logic            fire_edge;
   logic [9:0]      laser_x;
   logic [9:0]      laser_y;
   logic            laser_active;
   color_t          color_q;
   color_t          color_d;
   logic [10:0]     h_x;
   logic [10:0]     v_x;
   logic [10:0]     lx_x;
   logic [10:0]     ly_x;
   logic            in_laser;
   logic            in_body;
   logic            in_turret;

   assign move_ok   = bus.frameStart && (move_cnt == MV_LAST);
   assign fire_edge = bus.fire && !fire_d;

   // Frame divider: only every MOVE_DIV-th frame offers a move
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         move_cnt <= '0;
      end else if (bus.frameStart) begin
         move_cnt <= move_ok ? '0 : move_cnt + 1'b1;
      end
   end

   // Next gun position: single-direction requests move by STEP, clamped
   // to the playfield; the left clamp is tested before subtracting
   always_comb begin
      gun_ext   = {1'b0, gun_q};
      right_sum = gun_ext + STEP_X;
      next_gun  = gun_q;
      if (move_ok && bus.right && !bus.left) begin
         next_gun = (right_sum > PMAX_X) ? 10'(PMAX_X) : 10'(right_sum);
      end else if (move_ok && bus.left && !bus.right) begin
         next_gun = (gun_ext < PMIN_X + STEP_X) ? 10'(PMIN_X) : 10'(gun_ext - STEP_X);
      end
   end

   // Gun register and the fire delay used for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gun_q  <= 10'(SCREEN_WIDTH / 2);
         fire_d <= 1'b0;
      end else begin
         gun_q  <= next_gun;
         fire_d <= bus.fire;
      end
   end

   // The shot captures gun_q, i.e. the position before any same-cycle move
   laser_shot #(
      .LAUNCH_Y        (SHIP_TOP - LASER_LEN),
      .V_OFFSET        (V_OFFSET),
      .LASER_SPEED     (LASER_SPEED),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
   ) u_laser_shot (
      .clk          (clk),
      .reset        (reset),
      .fire_edge    (fire_edge),
      .frame_start  (bus.frameStart),
      .laser_hit    (bus.laserHit),
      .gun_position (gun_q),
      .laser_x      (laser_x),
      .laser_y      (laser_y),
      .laser_active (laser_active)
   );

   // Pixel hit tests on half-open ranges; lower bounds are written as
   // pos + half >= centre so a centre near zero cannot underflow
   always_comb begin
      h_x       = {1'b0, bus.hPos};
      v_x       = {1'b0, bus.vPos};
      lx_x      = {1'b0, laser_x};
      ly_x      = {1'b0, laser_y};
      in_laser  = laser_active &&
                  (h_x + 11'd1 >= lx_x) && (h_x < lx_x + 11'd1) &&
                  (v_x >= ly_x) && (v_x < ly_x + LEN_X);
      in_body   = (h_x + HALF_W_X >= gun_ext) && (h_x < gun_ext + HALF_W_X) &&
                  (v_x >= MID_X) && (v_x < BOTTOM_X);
      in_turret = (h_x + HALF_RECT_X >= gun_ext) && (h_x < gun_ext + HALF_RECT_X) &&
                  (v_x >= TOP_X) && (v_x < MID_X);
      color_d   = NONE;
      if (in_laser) begin
         color_d = LASER;
      end else if (in_body || in_turret) begin
         color_d = SPACESHIP;
      end
   end

   // Colour is registered, so it lags hPos/vPos by one clock
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         color_q <= NONE;
      end else begin
         color_q <= color_d;
      end
   end

   assign bus.gunPosition = gun_q;
   assign bus.laserX      = laser_x;
   assign bus.laserY      = laser_y;
   assign bus.laserActive = laser_active;
   assign bus.color       = color_q;

endmodule

// File: tb/tb_player_ship_ctrl.sv
// Directed bench for player_ship_ctrl: default build plus a STEP=30 build
// that exercises the partial-step clamp at the left edge.
module tb_player_ship_ctrl;

   logic clk;
   logic reset;
   int   assertCount;
   int   failCount;

   player_ship_ctrl_if bus ();
   player_ship_ctrl_if bus30 ();

   player_ship_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   player_ship_ctrl #(.STEP(30)) dut30 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus30)
   );

   // Free-running pixel clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison point: counts it and reports a miss
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance one clock and land just after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frameStart pulse followed by a couple of quiet clocks
   task automatic frame();
      bus.frameStart   = 1'b1;
      bus30.frameStart = 1'b1;
      tick();
      bus.frameStart   = 1'b0;
      bus30.frameStart = 1'b0;
      tick();
      tick();
   endtask

   task automatic applyStimulus(input logic l, input logic r, input logic f);
      bus.left  = l;
      bus.right = r;
      bus.fire  = f;
   endtask

   task automatic firePulse();
      bus.fire = 1'b1;
      tick();
      bus.fire = 1'b0;
      tick();
   endtask

   task automatic setPixel(input int h, input int v);
      bus.hPos = 10'(h);
      bus.vPos = 10'(v);
      tick();
   endtask

   task automatic doReset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      reset       = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      bus.frameStart   = 1'b0;
      bus.hPos         = '0;
      bus.vPos         = '0;
      bus.laserHit     = 1'b0;
      bus30.left       = 1'b0;
      bus30.right      = 1'b0;
      bus30.fire       = 1'b0;
      bus30.frameStart = 1'b0;
      bus30.hPos       = '0;
      bus30.vPos       = '0;
      bus30.laserHit   = 1'b0;

      // Reset values
      tick();
      tick();
      checkOutput("rst_gun", 16'(bus.gunPosition), 16'd320);
      checkOutput("rst_color", 16'(bus.color), 16'd7);
      checkOutput("rst_active", 16'(bus.laserActive), 16'd0);
      checkOutput("rst_lx", 16'(bus.laserX), 16'd0);
      checkOutput("rst_ly", 16'(bus.laserY), 16'd0);
      checkOutput("rst_gun30", 16'(bus30.gunPosition), 16'd320);

      // Idle frames change nothing
      reset = 1'b1;
      tick();
      frame();
      frame();
      frame();
      checkOutput("idle_gun", 16'(bus.gunPosition), 16'd320);
      checkOutput("idle_color", 16'(bus.color), 16'd7);
      checkOutput("idle_active", 16'(bus.laserActive), 16'd0);

      // Right held on the default build, left held on the STEP=30 build
      $display("[TB] movement");
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0);
      bus30.left = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         frame();
         if (i == 1)  checkOutput("right_f1", 16'(bus.gunPosition), 16'd320);
         if (i == 2)  checkOutput("right_f2", 16'(bus.gunPosition), 16'd340);
         if (i == 4)  checkOutput("right_f4", 16'(bus.gunPosition), 16'd360);
         if (i == 27) checkOutput("right_f27", 16'(bus.gunPosition), 16'd580);
         if (i == 28) checkOutput("right_f28", 16'(bus.gunPosition), 16'd600);
         if (i == 32) checkOutput("right_f32", 16'(bus.gunPosition), 16'd600);
         if (i == 2)  checkOutput("left30_f2", 16'(bus30.gunPosition), 16'd290);
         if (i == 18) checkOutput("left30_f18", 16'(bus30.gunPosition), 16'd50);
         if (i == 20) checkOutput("left30_f20", 16'(bus30.gunPosition), 16'd40);
         if (i == 32) checkOutput("left30_f32", 16'(bus30.gunPosition), 16'd40);
      end

      // Both directions at once hold position
      applyStimulus(1'b1, 1'b1, 1'b0);
      bus30.right = 1'b1;
      for (int i = 0; i < 4; i++) frame();
      checkOutput("both_gun", 16'(bus.gunPosition), 16'd600);
      checkOutput("both_gun30", 16'(bus30.gunPosition), 16'd40);
      applyStimulus(1'b0, 1'b0, 1'b0);
      bus30.left  = 1'b0;
      bus30.right = 1'b0;

      // Launch at the centre
      $display("[TB] laser launch and colour");
      doReset();
      bus.fire = 1'b1;
      tick();
      checkOutput("launch_active", 16'(bus.laserActive), 16'd1);
      checkOutput("launch_lx", 16'(bus.laserX), 16'd320);
      checkOutput("launch_ly", 16'(bus.laserY), 16'd428);
      bus.fire = 1'b0;
      frame();
      checkOutput("fly_ly", 16'(bus.laserY), 16'd420);

      // Colour lookups, one clock after each pixel is presented
      setPixel(320, 425);
      checkOutput("pix_laser", 16'(bus.color), 16'd6);
      setPixel(319, 420);
      checkOutput("pix_laser_corner", 16'(bus.color), 16'd6);
      setPixel(321, 425);
      checkOutput("pix_laser_right", 16'(bus.color), 16'd7);
      setPixel(320, 445);
      checkOutput("pix_turret", 16'(bus.color), 16'd1);
      setPixel(300, 445);
      checkOutput("pix_beside_turret", 16'(bus.color), 16'd7);
      setPixel(290, 460);
      checkOutput("pix_body_left", 16'(bus.color), 16'd1);
      setPixel(350, 460);
      checkOutput("pix_body_right", 16'(bus.color), 16'd7);
      setPixel(0, 0);

      // Kill, then cooldown swallows fire edges for three frames
      $display("[TB] hit and cooldown");
      bus.laserHit = 1'b1;
      tick();
      bus.laserHit = 1'b0;
      checkOutput("hit_active", 16'(bus.laserActive), 16'd0);
      for (int i = 1; i <= 3; i++) begin
         frame();
         firePulse();
         checkOutput("cooldown_nofire", 16'(bus.laserActive), 16'd0);
      end
      frame();
      firePulse();
      checkOutput("refire_active", 16'(bus.laserActive), 16'd1);
      checkOutput("refire_ly", 16'(bus.laserY), 16'd428);

      // Shot climbs off the top while fire is held
      $display("[TB] shot exits top");
      bus.fire = 1'b1;
      for (int i = 0; i < 52; i++) frame();
      checkOutput("top_active", 16'(bus.laserActive), 16'd1);
      checkOutput("top_ly", 16'(bus.laserY), 16'd12);
      frame();
      checkOutput("top_exit", 16'(bus.laserActive), 16'd0);
      for (int i = 0; i < 5; i++) frame();
      checkOutput("hold_norefire", 16'(bus.laserActive), 16'd0);
      bus.fire = 1'b0;
      tick();

      // Asynchronous reset in the middle of a flight
      $display("[TB] async reset mid-flight");
      applyStimulus(1'b0, 1'b1, 1'b0);
      frame();
      frame();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_gun", 16'(bus.gunPosition), 16'd340);
      firePulse();
      checkOutput("pre_rst_active", 16'(bus.laserActive), 16'd1);
      checkOutput("pre_rst_lx", 16'(bus.laserX), 16'd340);
      reset = 1'b0;
      #1;
      checkOutput("async_active", 16'(bus.laserActive), 16'd0);
      checkOutput("async_gun", 16'(bus.gunPosition), 16'd320);
      checkOutput("async_lx", 16'(bus.laserX), 16'd0);
      checkOutput("async_color", 16'(bus.color), 16'd7);
      tick();
      reset = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
